// File: rtl/pop_mode_controller.sv
// pop_mode_controller: debounces the front-panel buttons, sequences the operating mode,
// issues one-cycle command strobes and drives the registered output pins per mode.
module pop_mode_controller #(
    parameter int unsigned DEBOUNCE_SAMPLES = 4,
    parameter logic [1:0]  RESET_MODE       = 2'd0
) (
    input  logic       clk_2M5,
    input  logic       reset,
    input  logic       debounce_pulse,
    input  logic       slow_pulse,
    input  logic       fast_pulse,
    input  logic       mode_button_n,
    input  logic       load_default_button_n,
    input  logic       topleft_button_n,
    input  logic       topright_button_n,
    input  logic       bottomleft_button_n,
    input  logic       bottomright_button_n,
    input  logic       pump_in,
    input  logic       probe_in,
    input  logic       MW_in,
    input  logic       sample_in,
    output logic [1:0] state,
    output logic       load_defaults,
    output logic       pieovertwo_plus,
    output logic       freeprecess_plus,
    output logic       pieovertwo_minus,
    output logic       freeprecess_minus,
    output logic       LED_output,
    output logic       pump_output,
    output logic       probe_output,
    output logic       MW_output,
    output logic       sample_output
);
    localparam int NB = 6;
    localparam int CW = $clog2(DEBOUNCE_SAMPLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SAMPLES - 1);

    typedef enum logic [1:0] {
        LASER_SETUP = 2'd0,
        POP_CYCLE   = 2'd1,
        DARK        = 2'd2,
        PUMP_CAL    = 2'd3
    } mode_e;

    // Button order: 0 mode, 1 load, 2 topleft, 3 topright, 4 bottomleft, 5 bottomright
    logic [NB-1:0]         raw_n;
    logic [NB-1:0]         sync1_q, sync2_q, sample;
    logic                  dp_q, tick;
    logic [NB-1:0]         db_q, db_d, db_prev_q, press;
    logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
    mode_e                 state_q, state_d;
    logic [4:0]            strobe_q, strobe_d;
    logic [4:0]            pins_q, pins_d;
    logic [3:0]            adjust;

    assign raw_n  = {bottomright_button_n, bottomleft_button_n, topright_button_n,
                     topleft_button_n, load_default_button_n, mode_button_n};
    assign sample = ~sync2_q;
    assign tick   = debounce_pulse & ~dp_q;
    assign press  = db_q & ~db_prev_q;

    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            dp_q      <= 1'b0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= raw_n;
            sync2_q   <= sync1_q;
            dp_q      <= debounce_pulse;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    // A change is accepted only after DEBOUNCE_SAMPLES consecutive differing ticks
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NB; i++) begin
            if (tick) begin
                if (sample[i] == db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]  = sample[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_2M5) begin
        if (reset) state_q <= mode_e'(RESET_MODE);
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = press[0] ? mode_e'(state_q + 2'd1) : state_q;
    end

    // Adjust strobes only in POPcycle, and a simultaneous mode press wins over them
    always_comb begin
        adjust   = (state_q == POP_CYCLE && !press[0]) ? {press[2], press[3], press[4], press[5]} : 4'b0;
        strobe_d = {press[1], adjust};
        pins_d   = 5'b0;
        unique case (state_q)
            LASER_SETUP: pins_d = {slow_pulse, 1'b0, 1'b1, 1'b0, 1'b1};
            POP_CYCLE:   pins_d = {1'b1, pump_in, probe_in, MW_in, sample_in};
            DARK:        pins_d = {fast_pulse, 1'b0, 1'b0, 1'b0, 1'b1};
            PUMP_CAL:    pins_d = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        endcase
    end

    always_ff @(posedge clk_2M5) begin
        if (reset) begin
            strobe_q <= '0;
            pins_q   <= '0;
        end else begin
            strobe_q <= strobe_d;
            pins_q   <= pins_d;
        end
    end

    assign state = state_q;
    assign {load_defaults, pieovertwo_plus, freeprecess_plus, pieovertwo_minus, freeprecess_minus} = strobe_q;
    assign {LED_output, pump_output, probe_output, MW_output, sample_output} = pins_q;
endmodule
